// File: rtl/new_feature_loader.sv
`default_nettype none
// ============================================================================
//  Module   : new_feature_loader
//  Brief    : Reads layer-1 new-feature BRAM back node by node, reassembles
//             each node's word vector, optionally applies ReLU and presents
//             it to the layer-2 weight-multiply stage over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module new_feature_loader #(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int RD_LATENCY        = 1,
    parameter int APPLY_RELU        = 1,
    parameter int ADDR_W            = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
    parameter int NODE_W            = $clog2(NUM_SUBGRAPHS)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    output logic                                         feat_bram_enb,
    output logic [ADDR_W-1:0]                            feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]                 feat_bram_doutb,
    output logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] feat_vec,
    output logic                                         feat_vec_vld,
    input  logic                                         feat_vec_rdy,
    output logic [NODE_W-1:0]                            node_idx,
    output logic                                         done
);

    localparam int W         = NEW_FEATURE_WIDTH;
    localparam int c_k_width = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;

    localparam logic [c_k_width-1:0] c_k_last    = c_k_width'(NUM_FEATURE_OUT - 1);
    localparam logic [c_k_width-1:0] c_k_one     = c_k_width'(1);
    localparam logic [NODE_W-1:0]    c_node_last = NODE_W'(NUM_SUBGRAPHS - 1);
    localparam logic [NODE_W-1:0]    c_node_one  = NODE_W'(1);
    localparam logic [ADDR_W-1:0]    c_addr_one  = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    state_t                           r_state, w_state_nxt;
    logic                             r_enb, w_enb_nxt;
    logic [ADDR_W-1:0]                r_addr, w_addr_nxt;
    logic [c_k_width-1:0]             r_k, w_k_nxt;
    logic                             r_vld, w_vld_nxt;
    logic [NODE_W-1:0]                r_node, w_node_nxt;
    logic                             r_done, w_done_nxt;
    logic [NUM_FEATURE_OUT*W-1:0]     r_feat_vec;

    // Read pipeline: tracks which word index each outstanding read carries.
    logic                             r_pipe_vld [RD_LATENCY];
    logic [c_k_width-1:0]             r_pipe_k   [RD_LATENCY];

    logic                             w_cap_vld;
    logic [c_k_width-1:0]             w_cap_k;
    logic [c_k_width-1:0]             w_elem;
    logic                             w_cap_last;
    logic [W-1:0]                     w_word;

    assign w_cap_vld  = r_pipe_vld[RD_LATENCY-1];
    assign w_cap_k    = r_pipe_k[RD_LATENCY-1];
    // Highest element is stored first, so word k lands in element F-1-k.
    assign w_elem     = c_k_last - w_cap_k;
    assign w_cap_last = w_cap_vld && (w_cap_k == c_k_last);

    generate
        if (APPLY_RELU != 0) begin : g_relu
            assign w_word = feat_bram_doutb[W-1] ? '0 : feat_bram_doutb;
        end else begin : g_pass
            assign w_word = feat_bram_doutb;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_enb_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        w_k_nxt     = r_k;
        w_vld_nxt   = r_vld;
        w_node_nxt  = r_node;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_addr_nxt = '0;
                w_node_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_FETCH;
                    w_enb_nxt   = 1'b1;
                    w_k_nxt     = '0;
                end
            end
            ST_FETCH: begin
                // Running address: one step per issued read, never rebased per node.
                w_addr_nxt = r_addr + c_addr_one;
                if (r_k == c_k_last) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_enb_nxt = 1'b1;
                    w_k_nxt   = r_k + c_k_one;
                end
            end
            ST_WAIT: begin
                if (w_cap_last) begin
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (r_vld && feat_vec_rdy) begin
                    w_vld_nxt = 1'b0;
                    if (r_node == c_node_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_node_nxt  = r_node + c_node_one;
                        w_state_nxt = ST_FETCH;
                        w_enb_nxt   = 1'b1;
                        w_k_nxt     = '0;
                    end
                end
            end
            ST_FIN: begin
                w_node_nxt  = '0;
                w_addr_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enb  <= 1'b0;
            r_addr <= '0;
            r_k    <= '0;
            r_vld  <= 1'b0;
            r_node <= '0;
            r_done <= 1'b0;
        end else begin
            r_enb  <= w_enb_nxt;
            r_addr <= w_addr_nxt;
            r_k    <= w_k_nxt;
            r_vld  <= w_vld_nxt;
            r_node <= w_node_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Read pipeline shift register, entry 0 loaded on each issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_k[i]   <= '0;
            end
        end else begin
            r_pipe_vld[0] <= r_enb;
            r_pipe_k[0]   <= r_k;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_k[i]   <= r_pipe_k[i-1];
            end
        end
    end

    // Vector assembly: returning word written into its element slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat_vec <= '0;
        end else if (w_cap_vld) begin
            for (int e = 0; e < NUM_FEATURE_OUT; e++) begin
                if (w_elem == c_k_width'(e)) r_feat_vec[e*W +: W] <= w_word;
            end
        end
    end

    assign feat_bram_enb   = r_enb;
    assign feat_bram_addrb = r_addr;
    assign feat_vec        = r_feat_vec;
    assign feat_vec_vld    = r_vld;
    assign node_idx        = r_node;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: doc/new_feature_loader.md
Name: new_feature_loader

Overview:
- Downstream consumer of the new-feature BRAM written by the layer-1 feature write stage.
- After layer-1 completion, it reads the BRAM back one node at a time and reassembles each node's NUM_FEATURE_OUT scalar words into one vector.
- Optionally applies ReLU, then hands each vector to the layer-2 weight-multiply stage over a valid/ready handshake.

Parameters:
- NEW_FEATURE_WIDTH, 32, width of one stored feature word (two's complement)
- NUM_FEATURE_OUT, 16, words per node vector (F)
- NUM_SUBGRAPHS, 2708, number of node vectors stored (N)
- RD_LATENCY, 1, BRAM read latency in cycles (enb/addrb sampled to doutb valid); legal range 1..3
- APPLY_RELU, 1, 1 = clamp negative words to 0 before output; 0 = pass through
- Derived: ADDR_W = $clog2(N*F); NODE_W = $clog2(N)

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level or pulse; sampled only in IDLE (driven by layer-1 gat_ready).
- feat_bram_enb  output  1  BRAM port-B read enable.
- feat_bram_addrb  output  ADDR_W  BRAM port-B read address.
- feat_bram_doutb  input  NEW_FEATURE_WIDTH  BRAM read data.
- feat_vec  output  F*NEW_FEATURE_WIDTH  packed vector; element e = bits [e*W +: W].
- feat_vec_vld  output  1  vector valid.
- feat_vec_rdy  input  1  downstream ready.
- node_idx  output  NODE_W  index of the node currently presented.
- done  output  1  one-cycle pulse after the last vector is accepted.

Behaviour:
- All outputs are registered.
- Reset: enb=0, addrb=0, feat_vec=0, vld=0, node_idx=0, done=0; state=IDLE; read pipeline and counters cleared.
- Reset asserted mid-operation aborts immediately; no output is retained.
- Storage layout: node n occupies addresses n*F .. n*F+F-1. The word at address n*F+k is element F-1-k (highest element is stored first).
- Addressing uses a running address counter that increments by 1 per read and is never reset between nodes. No multiplier.
- FSM states: IDLE, FETCH, WAIT, PRESENT, FIN.
  - IDLE: start=1 -> FETCH. The same edge drives enb=1, addrb=0 and loads word counter k=0.
  - FETCH: enb=1 for exactly F consecutive cycles with addrb incrementing by 1 each cycle. After the F-th read issue -> WAIT, with enb=0.
  - Read pipeline: an RD_LATENCY-deep shift register of {valid, k}. Captured word = doutb, through ReLU (if APPLY_RELU and MSB=1, then 0), written into element F-1-k.
  - WAIT: stays until the last pipeline entry is captured. That capture edge also sets vld=1 -> PRESENT.
  - PRESENT: feat_vec and node_idx are stable while vld=1. On vld&&rdy at edge H:
    - if node_idx<N-1: node_idx+1, vld=0 -> FETCH, with enb=1 and the next address driven from edge H;
    - else: vld=0, done=1 -> FIN.
  - FIN: done=0 -> IDLE. node_idx and the address counter return to 0.
- Latency: vld rises F+RD_LATENCY cycles after the edge that samples start, or after the handshake edge of the previous vector. Default: 17 cycles. There are no bubbles beyond that.
- start while not in IDLE: ignored. start held high after FIN: a new full pass begins.
- rdy high while vld=0: no effect. rdy low: the vector holds indefinitely; no BRAM reads are issued.
- No read is ever issued past address N*F-1.

Test Plan:
- Params F=4, N=3, RD_LATENCY=1, APPLY_RELU=0. BRAM[a]=a+0x10. Pulse start, rdy=1.
  -> Vector 0 = {e3..e0} = {0x10,0x11,0x12,0x13}, i.e. e3=0x10, e0=0x13.
  -> vld rises 5 cycles after the start edge.
  -> node_idx is 0, then 1, then 2.
  -> done pulses once, 1 cycle after the 3rd accept.
- Same setup, rdy=0 for 10 cycles once vld rises.
  -> feat_vec, node_idx and vld are stable; enb stays 0 throughout.
  -> When rdy rises, accept occurs at that edge and enb rises on the same edge.
- APPLY_RELU=1, BRAM[0..3] = {0xFFFFFFFF, 5, 0x80000000, 0x7FFFFFFF}.
  -> e3=0, e2=5, e1=0, e0=0x7FFFFFFF.
- RD_LATENCY=3, full pass.
  -> vld rises 7 cycles after start; data matches scenario 1.
  -> The highest enb address is 11.
- Assert rst_n low mid-FETCH of node 1.
  -> All outputs are 0 asynchronously.
  -> After release and a new start, node_idx restarts at 0 and the first address is 0.
- start held high during PRESENT and again after done.
  -> No restart mid-pass.
  -> A second full pass starts from the IDLE edge after FIN.
